// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: syncs, debounces and priority-encodes a 10-line
// keypad and accumulates BCD digits.
// Ports: clk, rst (async, active high); key_in[9:0] raw keys;
//   enter/clear commands; out_valid/out_ready handshake;
//   out_digits, out_count, cur_digit, digit_strobe, overflow.
module keypad_entry_ctrl #(
  parameter  int NUM_DIGITS = 4,
  parameter  int DEB_CYCLES = 4,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int DW = 4 * NUM_DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    key_in,
  input  logic          enter,
  input  logic          clear,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_digits,
  output logic [CW-1:0] out_count,
  output logic [3:0]    cur_digit,
  output logic          digit_strobe,
  output logic          overflow
);

  localparam int NW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE,
    SEND
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    s1_q, ks_q;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cur_q, cur_d;
  logic          strobe_q, strobe_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;

  logic          key_any;
  logic [3:0]    enc;
  logic          full;
  logic          last;

  // Highest-numbered pressed key wins.
  function automatic logic [3:0] enc_f(input logic [9:0] k);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign key_any = |ks_q;
  assign enc     = enc_f(ks_q);
  assign full    = (count_q == CW'(NUM_DIGITS));
  assign last    = (cnt_q == NW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      ks_q <= '0;
    end else begin
      s1_q <= key_in;
      ks_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      buf_q    <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    buf_d    = buf_q;
    count_d  = count_q;
    cur_d    = cur_q;
    strobe_d = 1'b0;
    ovf_d    = 1'b0;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        if (key_any) begin
          cand_d  = enc;
          cnt_d   = NW'(1);
          state_d = DEB_PRESS;
        end else if (enter && count_q != '0 && !clear) begin
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      DEB_PRESS: begin
        if (key_any && enc == cand_q) begin
          if (last) begin
            state_d = HELD;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              buf_d    = {buf_q[DW-5:0], cand_q};
              count_d  = count_q + CW'(1);
              cur_d    = cand_q;
              strobe_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!key_any) begin
          cnt_d   = NW'(1);
          state_d = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (key_any) begin
          state_d = HELD;
        end else if (last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          buf_d   = '0;
          count_d = '0;
          state_d = key_any ? HELD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides any concurrent insert; pulses are left untouched.
    if (clear && state_q != SEND) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  assign out_valid    = valid_q;
  assign out_digits   = buf_q;
  assign out_count    = count_q;
  assign cur_digit    = cur_q;
  assign digit_strobe = strobe_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: directed plan steps plus random key
// activity compared each cycle against a run-length reference model.
module tb_keypad_entry_ctrl;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  key_in;
  logic        enter, clear, out_ready;
  logic        out_valid;
  logic [15:0] out_digits;
  logic [2:0]  out_count;
  logic [3:0]  cur_digit;
  logic        digit_strobe, overflow;

  keypad_entry_ctrl #(.NUM_DIGITS(N), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .enter(enter),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid),
    .out_digits(out_digits), .out_count(out_count),
    .cur_digit(cur_digit), .digit_strobe(digit_strobe),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_ovf = 0;
  int last_strobe = 0;

  // Reference model state
  logic [9:0] m_s1, m_ks;
  int  run, rel, cand, m_cur;
  bit  held, sending, m_valid, m_strobe, m_ovf;
  int  q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_digits();
    logic [15:0] d = 16'h0;
    foreach (q[i]) d = (d << 4) | 16'(q[i]);
    return d;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_ks = '0;
    run = 0; rel = 0; cand = 0; m_cur = 0;
    held = 0; sending = 0; m_valid = 0;
    m_strobe = 0; m_ovf = 0;
    q.delete();
  endtask

  task automatic model_edge();
    bit any;
    int e;
    any = (m_ks != 0);
    e = $clog2(int'(m_ks) + 1) - 1;
    m_strobe = 0;
    m_ovf = 0;
    if (sending) begin
      if (m_valid && out_ready) begin
        m_valid = 0;
        sending = 0;
        q.delete();
        if (any) begin held = 1; rel = 0; end
      end
    end else begin
      if (held) begin
        rel = any ? 0 : rel + 1;
        if (rel == DEB) held = 0;
      end else if (run == 0) begin
        if (any) begin
          cand = e; run = 1;
        end else if (enter && q.size() > 0 && !clear) begin
          sending = 1; m_valid = 1;
        end
      end else if (any && e == cand) begin
        run++;
        if (run == DEB) begin
          run = 0; held = 1; rel = 0;
          if (q.size() == N) m_ovf = 1;
          else begin
            q.push_back(cand); m_cur = cand; m_strobe = 1;
          end
        end
      end else begin
        run = 0;
      end
      if (clear) q.delete();
    end
    m_ks = m_s1;
    m_s1 = key_in;
  endtask

  task automatic check_all();
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("digits", 32'(out_digits), 32'(m_digits()));
    chk("count", 32'(out_count), 32'(q.size()));
    chk("cur", 32'(cur_digit), 32'(m_cur));
    chk("strobe", 32'(digit_strobe), 32'(m_strobe));
    chk("ovf", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic [9:0] k, input logic e,
                      input logic c, input logic r);
    key_in = k; enter = e; clear = c; out_ready = r;
    model_edge();
    @(posedge clk); #1;
    cyc++;
    check_all();
    if (digit_strobe) begin n_strobe++; last_strobe = cyc; end
    if (overflow) n_ovf++;
  endtask

  task automatic press(input logic [9:0] m, input int hold,
                       input int relc);
    for (int i = 0; i < hold; i++) step(m, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < relc; i++) step(10'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int c0, s0, o0;
    logic [9:0] m;
    rst = 1'b1;
    key_in = '0; enter = 0; clear = 0; out_ready = 1;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single key 5, strobe in cycle 6
    c0 = cyc; s0 = n_strobe;
    press(10'h020, 12, 10);
    chk("t1_strobes", 32'(n_strobe - s0), 32'd1);
    chk("t1_cycle", 32'(last_strobe - c0), 32'd6);
    chk("t1_cur", 32'(cur_digit), 32'd5);
    chk("t1_low", 32'(out_digits[3:0]), 32'd5);

    // 2: bounce on key 3
    s0 = n_strobe;
    press(10'h008, 2, 1);
    press(10'h008, 2, 1);
    chk("t2_bounce", 32'(n_strobe - s0), 32'd0);
    press(10'h008, 10, 8);
    chk("t2_strobes", 32'(n_strobe - s0), 32'd1);
    chk("t2_cur", 32'(cur_digit), 32'd3);

    // 3: priority and key change while held
    s0 = n_strobe;
    press(10'h084, 8, 0);
    press(10'h002, 8, 8);
    chk("t3_strobes", 32'(n_strobe - s0), 32'd1);
    chk("t3_cur", 32'(cur_digit), 32'd7);

    // 4: fill buffer and overflow
    step(10'h0, 1'b0, 1'b1, 1'b1);
    s0 = n_strobe; o0 = n_ovf;
    for (int d = 1; d <= 5; d++) press(10'(1 << d), 8, 8);
    chk("t4_digits", 32'(out_digits), 32'h1234);
    chk("t4_count", 32'(out_count), 32'd4);
    chk("t4_ovf", 32'(n_ovf - o0), 32'd1);
    chk("t4_strobes", 32'(n_strobe - s0), 32'd4);

    // 5: submit 0x0042 with delayed ready
    step(10'h0, 1'b0, 1'b1, 1'b1);
    press(10'h010, 8, 8);
    press(10'h004, 8, 8);
    step(10'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(10'h0, 1'b0, 1'b0, 1'b0);
      chk("t5_hold_v", 32'(out_valid), 32'd1);
      chk("t5_hold_d", 32'(out_digits), 32'h0042);
    end
    step(10'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_v", 32'(out_valid), 32'd0);
    chk("t5_cnt", 32'(out_count), 32'd0);
    chk("t5_dig", 32'(out_digits), 32'd0);

    // 6: clear in accept cycle, then reset during debounce
    press(10'h002, 8, 8);
    s0 = n_strobe;
    for (int i = 0; i < 5; i++) step(10'h010, 1'b0, 1'b0, 1'b1);
    step(10'h010, 1'b0, 1'b1, 1'b1);
    chk("t6_strobe", 32'(digit_strobe), 32'd1);
    chk("t6_count", 32'(out_count), 32'd0);
    press(10'h010, 2, 8);
    press(10'h040, 8, 8);
    press(10'h100, 4, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1 rst = 1'b0;
    s0 = n_strobe;
    press(10'h100, 8, 8);
    chk("t6_after", 32'(n_strobe - s0), 32'd1);
    chk("t6_cur", 32'(cur_digit), 32'd8);

    // Random traffic
    for (int ep = 0; ep < 300; ep++) begin
      if ($urandom_range(0, 2) == 0) m = 10'($urandom);
      else m = 10'(1 << $urandom_range(0, 9));
      for (int i = 0; i < int'($urandom_range(0, 9)); i++)
        step(m, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
             1'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 9)); i++)
        step(10'h0, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 15) == 0), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
